// File: rtl/vend_seq.sv
// Drink vending sequencer: coin credit accumulation, then dispense and change/refund
// handshakes towards the drink mechanism and the coin hopper.
module vend_seq #(
   parameter int unsigned PRICE       = 5,
   parameter int unsigned CREDIT_W    = 4,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                half,
   input  logic                one,
   input  logic                cancel,
   input  logic                disp_ack,
   input  logic                chg_ack,
   output logic                drink,
   output logic                change,
   output logic [CREDIT_W-1:0] change_amt,
   output logic [CREDIT_W-1:0] credit,
   output logic                coin_rej,
   output logic                busy
);

   localparam int unsigned SUM_W   = CREDIT_W + 1;
   localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYC);
   localparam logic [SUM_W-1:0]    CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
   localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
   localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_DISPENSE,
      S_CHANGE
   } state_t;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic                drink_q, drink_d;
   logic                change_q, change_d;
   logic                coin_rej_q, coin_rej_d;
   logic                busy_q, busy_d;

   logic                coin_any;
   logic [SUM_W-1:0]    coin_val;
   logic [SUM_W-1:0]    credit_sum;
   logic                coin_fits;

   // Next-state, credit and output decode
   always_comb begin
      state_d      = state_q;
      credit_d     = credit_q;
      change_amt_d = change_amt_q;
      timer_d      = '0;
      coin_rej_d   = 1'b0;
      coin_any     = half | one;
      coin_val     = SUM_W'({one, half});
      credit_sum   = SUM_W'(credit_q) + coin_val;
      coin_fits    = (credit_sum <= CREDIT_MAX);

      case (state_q)
         S_IDLE: begin
            if (coin_any) begin
               credit_d = credit_sum[CREDIT_W-1:0];
               state_d  = S_COLLECT;
            end
         end
         S_COLLECT: begin
            // Half+one together is all-or-nothing when it would overflow
            if (coin_any) begin
               if (coin_fits) credit_d = credit_sum[CREDIT_W-1:0];
               else           coin_rej_d = 1'b1;
            end
            if (coin_any)                 timer_d = '0;
            else if (timer_q == TIMER_LAST) timer_d = timer_q;
            else                          timer_d = timer_q + TIMER_W'(1);

            if (credit_q >= PRICE_C) begin
               state_d = S_DISPENSE;
            end else if (cancel || (!coin_any && (timer_q == TIMER_LAST))) begin
               state_d      = S_CHANGE;
               change_amt_d = credit_d;
            end
         end
         S_DISPENSE: begin
            coin_rej_d = coin_any;
            if (disp_ack) begin
               credit_d = credit_q - PRICE_C;
               if (credit_d != '0) begin
                  state_d      = S_CHANGE;
                  change_amt_d = credit_d;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_CHANGE: begin
            coin_rej_d = coin_any;
            if (chg_ack) begin
               credit_d     = '0;
               change_amt_d = '0;
               state_d      = S_IDLE;
            end
         end
         default: begin
            state_d      = S_IDLE;
            credit_d     = '0;
            change_amt_d = '0;
         end
      endcase

      if (state_d != S_COLLECT) timer_d = '0;

      drink_d  = (state_d == S_DISPENSE);
      change_d = (state_d == S_CHANGE);
      busy_d   = drink_d | change_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         credit_q     <= '0;
         change_amt_q <= '0;
         timer_q      <= '0;
         drink_q      <= 1'b0;
         change_q     <= 1'b0;
         coin_rej_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         credit_q     <= credit_d;
         change_amt_q <= change_amt_d;
         timer_q      <= timer_d;
         drink_q      <= drink_d;
         change_q     <= change_d;
         coin_rej_q   <= coin_rej_d;
         busy_q       <= busy_d;
      end
   end

   assign drink      = drink_q;
   assign change     = change_q;
   assign change_amt = change_amt_q;
   assign credit     = credit_q;
   assign coin_rej   = coin_rej_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_vend_seq.sv
// Bench for vend_seq: directed vector table, reset/timeout sequences, and
// random stimulus compared against a cycle-level behavioural model.
module tb_vend_seq;

   localparam int PRICE = 13;
   localparam int CW    = 4;
   localparam int CMAX  = 15;
   localparam int TO    = 20;

   logic          clk, rst_n;
   logic          half, one, cancel, disp_ack, chg_ack;
   logic          drink, change, coin_rej, busy;
   logic [CW-1:0] change_amt, credit;

   vend_seq #(.PRICE(PRICE), .CREDIT_W(CW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .half(half), .one(one), .cancel(cancel),
      .disp_ack(disp_ack), .chg_ack(chg_ack), .drink(drink), .change(change),
      .change_amt(change_amt), .credit(credit), .coin_rej(coin_rej), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   // Behavioural model: where 0=idle 1=collecting 2=dispensing 3=paying change
   int m_where, m_credit, m_amt, m_rej, m_cyc, m_last;

   typedef struct {
      bit h, o, c, da, ca;
      bit e_drink, e_change;
      int e_credit, e_amt;
      bit e_rej;
   } vec_t;

   vec_t tbl[25];

   function automatic vec_t mk(bit h, bit o, bit c, bit da, bit ca,
                               bit ed, bit ec, int ecr, int ea, bit er);
      vec_t v;
      v.h = h; v.o = o; v.c = c; v.da = da; v.ca = ca;
      v.e_drink = ed; v.e_change = ec; v.e_credit = ecr; v.e_amt = ea; v.e_rej = er;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_where = 0; m_credit = 0; m_amt = 0; m_rej = 0; m_cyc = 0; m_last = 0;
   endtask

   task automatic m_step(input bit h, input bit o, input bit c, input bit da, input bit ca);
      int  v;
      bit  ready, timed;
      v = int'(h) + 2 * int'(o);
      m_cyc++;
      m_rej = 0;
      case (m_where)
         0: if (v > 0) begin m_credit += v; m_where = 1; m_last = m_cyc; end
         1: begin
            ready = (m_credit >= PRICE);
            timed = (v == 0) && (m_cyc - m_last == TO);
            if (v > 0) begin
               m_last = m_cyc;
               if (m_credit + v <= CMAX) m_credit += v;
               else m_rej = 1;
            end
            if (ready) m_where = 2;
            else if (c || timed) begin m_where = 3; m_amt = m_credit; end
         end
         2: begin
            m_rej = (v > 0);
            if (da) begin
               m_credit -= PRICE;
               if (m_credit > 0) begin m_where = 3; m_amt = m_credit; end
               else m_where = 0;
            end
         end
         default: begin
            m_rej = (v > 0);
            if (ca) begin m_credit = 0; m_amt = 0; m_where = 0; end
         end
      endcase
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".drink"},    int'(drink),      int'(m_where == 2));
      chk({tag, ".change"},   int'(change),     int'(m_where == 3));
      chk({tag, ".busy"},     int'(busy),       int'(m_where >= 2));
      chk({tag, ".credit"},   int'(credit),     m_credit);
      chk({tag, ".amt"},      int'(change_amt), (m_where == 3) ? m_amt : 0);
      chk({tag, ".coin_rej"}, int'(coin_rej),   m_rej);
   endtask

   // Apply one cycle of inputs, advance the model at the edge, sample 1ns later
   task automatic step(input bit h, input bit o, input bit c, input bit da, input bit ca);
      half = h; one = o; cancel = c; disp_ack = da; chg_ack = ca;
      @(posedge clk);
      m_step(h, o, c, da, ca);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".drink"},  int'(drink),  0);
      chk({tag, ".change"}, int'(change), 0);
      chk({tag, ".busy"},   int'(busy),   0);
      chk({tag, ".credit"}, int'(credit), 0);
   endtask

   initial begin
      int k;
      bit seen;
      rst_n = 1'b0;
      half = 0; one = 0; cancel = 0; disp_ack = 0; chg_ack = 0;
      m_reset();
      #12;
      chk_zero("reset");
      chk("reset.amt", int'(change_amt), 0);
      chk("reset.rej", int'(coin_rej), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table: price 13, 4-bit credit
      tbl[0]  = mk(0,1,0,0,0, 0,0, 2,0,0);
      tbl[1]  = mk(0,1,0,0,0, 0,0, 4,0,0);
      tbl[2]  = mk(1,1,0,0,0, 0,0, 7,0,0);
      tbl[3]  = mk(1,1,0,0,0, 0,0,10,0,0);
      tbl[4]  = mk(0,1,0,0,0, 0,0,12,0,0);
      tbl[5]  = mk(0,0,0,0,0, 0,0,12,0,0);
      tbl[6]  = mk(0,1,0,0,0, 0,0,14,0,0);
      tbl[7]  = mk(1,1,0,0,0, 1,0,14,0,1);
      tbl[8]  = mk(1,0,0,0,0, 1,0,14,0,1);
      tbl[9]  = mk(0,0,0,0,0, 1,0,14,0,0);
      tbl[10] = mk(0,0,0,1,0, 0,1, 1,1,0);
      tbl[11] = mk(1,0,0,0,0, 0,1, 1,1,1);
      tbl[12] = mk(0,0,0,0,1, 0,0, 0,0,0);
      tbl[13] = mk(1,0,0,0,0, 0,0, 1,0,0);
      tbl[14] = mk(0,1,0,0,0, 0,0, 3,0,0);
      tbl[15] = mk(0,0,1,0,0, 0,1, 3,3,0);
      tbl[16] = mk(0,0,0,1,0, 0,1, 3,3,0);
      tbl[17] = mk(0,0,0,0,1, 0,0, 0,0,0);
      tbl[18] = mk(1,1,0,0,0, 0,0, 3,0,0);
      tbl[19] = mk(1,1,0,0,0, 0,0, 6,0,0);
      tbl[20] = mk(1,1,0,0,0, 0,0, 9,0,0);
      tbl[21] = mk(1,1,0,0,0, 0,0,12,0,0);
      tbl[22] = mk(1,0,0,0,0, 0,0,13,0,0);
      tbl[23] = mk(0,0,0,0,0, 1,0,13,0,0);
      tbl[24] = mk(0,0,0,1,0, 0,0, 0,0,0);

      for (int i = 0; i < 25; i++) begin
         step(tbl[i].h, tbl[i].o, tbl[i].c, tbl[i].da, tbl[i].ca);
         chk($sformatf("tbl%0d.drink", i),  int'(drink),      int'(tbl[i].e_drink));
         chk($sformatf("tbl%0d.change", i), int'(change),     int'(tbl[i].e_change));
         chk($sformatf("tbl%0d.busy", i),   int'(busy),       int'(tbl[i].e_drink | tbl[i].e_change));
         chk($sformatf("tbl%0d.credit", i), int'(credit),     tbl[i].e_credit);
         chk($sformatf("tbl%0d.amt", i),    int'(change_amt), tbl[i].e_amt);
         chk($sformatf("tbl%0d.rej", i),    int'(coin_rej),   int'(tbl[i].e_rej));
      end

      // Timeout refund: half coin then idle until change rises
      step(1,0,0,0,0);
      seen = 0;
      k = 0;
      for (int i = 1; i <= 2 * TO && !seen; i++) begin
         step(0,0,0,0,0);
         if (change) begin seen = 1; k = i; end
      end
      chk("timeout.seen", int'(seen), 1);
      chk("timeout.cycle", k, TO);
      chk("timeout.amt", int'(change_amt), 1);
      chk_model("timeout");
      step(0,0,0,0,1);
      chk_zero("timeout.done");

      // Asynchronous reset in the middle of a dispense handshake
      for (int i = 0; i < 4; i++) step(1,1,0,0,0);
      step(0,1,0,0,0);
      step(0,0,0,0,0);
      chk("rst.pre_drink", int'(drink), 1);
      #3 rst_n = 1'b0;
      #1;
      chk_zero("rst.async");
      m_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
      step(0,0,0,1,0);
      chk_model("rst.after");
      step(1,0,0,0,0);
      chk_model("rst.alive");

      // Random stimulus against the model; coin rate varies per block
      for (int b = 0; b < 16; b++) begin
         int coin_div;
         coin_div = (b % 3 == 0) ? 40 : 5;
         for (int i = 0; i < 200; i++) begin
            bit h, o, c, da, ca;
            h  = ($urandom_range(0, coin_div - 1) == 0);
            o  = ($urandom_range(0, coin_div - 1) == 0);
            c  = ($urandom_range(0, 29) == 0);
            da = ($urandom_range(0, 3) == 0);
            ca = ($urandom_range(0, 3) == 0);
            step(h, o, c, da, ca);
            chk_model($sformatf("rnd%0d_%0d", b, i));
         end
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
